// File: rtl/adc_conv_sequencer.sv
// Host-side sequencer for a SAR ADC: drives the sample phase on st_conv,
// waits for the ADC done level and gives up after a timeout. Results are
// queued in a small first-word-fall-through FIFO. Supports single-shot and
// back-to-back continuous conversion.
module adc_conv_sequencer #(
  parameter int RES_W       = 12,
  parameter int SCYC_W      = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int FIFO_AW     = 2
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  input  logic [SCYC_W-1:0]  sample_cycles,
  output logic               st_conv,
  input  logic               adc_done,
  input  logic [RES_W-1:0]   adc_result,
  output logic               busy,
  input  logic               rd_en,
  output logic [RES_W-1:0]   rd_data,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               timeout,
  input  logic               clr_flags
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAMPLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  // Three cycles is the shortest sample phase in which the 2-flop
  // synchronizer can still observe the ADC dropping done.
  localparam logic [SCYC_W-1:0]  MIN_SAMPLE = SCYC_W'(3);
  localparam logic [SCYC_W-1:0]  ONE_S      = SCYC_W'(1);
  localparam logic [TO_W-1:0]    ZERO_T     = TO_W'(0);
  localparam logic [TO_W-1:0]    ONE_T      = TO_W'(1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [FIFO_AW:0]   CNT_ZERO   = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ZERO   = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [RES_W-1:0]   RES_ZERO   = RES_W'(0);

  logic [1:0]         state;
  logic               sync_meta;
  logic               done_s;
  logic [SCYC_W-1:0]  samp_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               armed;
  logic [RES_W-1:0]   cap_data;

  logic [RES_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  logic               wr_req;
  logic               do_push;
  logic               do_pop;
  logic               ovf_set;
  logic               to_hit;
  logic [FIFO_AW:0]   count_nxt;
  logic [FIFO_AW-1:0] rd_ptr_nxt;
  logic [RES_W-1:0]   head_nxt;

  function automatic logic [SCYC_W-1:0] clamp_sample(input logic [SCYC_W-1:0] s);
    return (s < MIN_SAMPLE) ? MIN_SAMPLE : s;
  endfunction

  // Bring the asynchronous ADC done level into the clkin domain.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      sync_meta <= adc_done;
      done_s    <= sync_meta;
    end
  end

  // Conversion FSM: sample phase, wait for done (armed by a seen drop), capture.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      st_conv  <= 1'b0;
      busy     <= 1'b0;
      samp_cnt <= {SCYC_W{1'b0}};
      to_cnt   <= ZERO_T;
      armed    <= 1'b0;
      cap_data <= RES_ZERO;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || continuous) begin
            state    <= S_SAMPLE;
            st_conv  <= 1'b1;
            busy     <= 1'b1;
            samp_cnt <= clamp_sample(sample_cycles);
            armed    <= 1'b0;
          end else begin
            st_conv  <= 1'b0;
            busy     <= 1'b0;
          end
        end
        S_SAMPLE: begin
          samp_cnt <= samp_cnt - ONE_S;
          to_cnt   <= ZERO_T;
          if (!done_s) begin
            armed <= 1'b1;
          end
          if (samp_cnt == ONE_S) begin
            state   <= S_CONVERT;
            st_conv <= 1'b0;
          end
        end
        S_CONVERT: begin
          to_cnt <= to_cnt + ONE_T;
          if (!done_s) begin
            armed <= 1'b1;
          end
          if (armed && done_s) begin
            state    <= S_CAPTURE;
            cap_data <= adc_result;
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (continuous) begin
            state    <= S_SAMPLE;
            st_conv  <= 1'b1;
            samp_cnt <= clamp_sample(sample_cycles);
            armed    <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          st_conv <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: push/pop qualification and the next head word for the FWFT output.
  always_comb begin
    wr_req     = (state == S_CAPTURE);
    to_hit     = (state == S_CONVERT) && !(armed && done_s) && (to_cnt == TO_LAST);
    do_pop     = rd_en && (fifo_count != CNT_ZERO);
    do_push    = wr_req && ((fifo_count != CNT_FULL) || do_pop);
    ovf_set    = wr_req && (fifo_count == CNT_FULL) && !do_pop;
    rd_ptr_nxt = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    case ({do_push, do_pop})
      2'b10:   count_nxt = fifo_count + CNT_ONE;
      2'b01:   count_nxt = fifo_count - CNT_ONE;
      default: count_nxt = fifo_count;
    endcase
    if (count_nxt == CNT_ZERO) begin
      head_nxt = RES_ZERO;
    end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = cap_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // FIFO storage; contents are discarded on reset simply by clearing the pointers.
  always_ff @(posedge clkin) begin
    if (do_push) begin
      mem[wr_ptr] <= cap_data;
    end
  end

  // FIFO pointers, occupancy and registered status/head outputs.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      wr_ptr     <= PTR_ZERO;
      rd_ptr     <= PTR_ZERO;
      fifo_count <= CNT_ZERO;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rd_data    <= RES_ZERO;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == CNT_ZERO);
      fifo_full  <= (count_nxt == CNT_FULL);
      rd_data    <= head_nxt;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (to_hit) begin
        timeout <= 1'b1;
      end else if (clr_flags) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed, table-driven bench for adc_conv_sequencer with a simple ADC model.
module tb_adc_conv_sequencer;

  localparam int RES_W       = 12;
  localparam int SCYC_W      = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int FIFO_AW     = 2;
  localparam int ADC_LAT     = 20;

  logic              clkin = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [SCYC_W-1:0] sample_cycles = 8'd0;
  logic              st_conv;
  logic              adc_done = 1'b0;
  logic [RES_W-1:0]  adc_result = 12'h000;
  logic              busy;
  logic              rd_en = 1'b0;
  logic [RES_W-1:0]  rd_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_AW:0]  fifo_count;
  logic              overflow;
  logic              timeout;
  logic              clr_flags = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int hi_cnt = 0;
  int last_width = 0;
  bit adc_enable = 1'b1;
  logic [RES_W-1:0] res_q [$];

  adc_conv_sequencer #(
    .RES_W(RES_W), .SCYC_W(SCYC_W), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_AW(FIFO_AW)
  ) dut (
    .clkin(clkin), .rst(rst), .start(start), .continuous(continuous),
    .sample_cycles(sample_cycles), .st_conv(st_conv), .adc_done(adc_done),
    .adc_result(adc_result), .busy(busy), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow), .timeout(timeout), .clr_flags(clr_flags)
  );

  always #5 clkin = ~clkin;

  // Free-running cycle index.
  always @(posedge clkin) cyc <= cyc + 1;

  // Measure the high width of each st_conv pulse in clkin cycles.
  always @(negedge clkin) begin
    if (st_conv) begin
      hi_cnt <= hi_cnt + 1;
    end else if (hi_cnt != 0) begin
      last_width <= hi_cnt;
      hi_cnt <= 0;
    end
  end

  // ADC model: done drops when sampling starts.
  always @(posedge st_conv) adc_done = 1'b0;

  // ADC model: done rises ADC_LAT cycles after st_conv falls, with the next queued result.
  always begin
    @(negedge st_conv);
    if (!rst && adc_enable) begin
      repeat (ADC_LAT) @(posedge clkin);
      #2;
      if (!st_conv) begin
        adc_result = (res_q.size() > 0) ? res_q.pop_front() : 12'hFFF;
        adc_done = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clkin);
      n++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  task automatic wait_done_rise(input string name);
    int n = 0;
    bit prev = adc_done;
    bit found = 1'b0;
    while (!found && n < 300) begin
      @(negedge clkin);
      if (adc_done && !prev) found = 1'b1;
      prev = adc_done;
      n++;
    end
    if (!found) begin
      n_total++;
      $display("FAIL %s: adc_done rise not seen in %0d cycles, expected a rise", name, n);
    end
  endtask

  task automatic pulse_start(input logic [SCYC_W-1:0] sc);
    sample_cycles = sc;
    start = 1'b1;
    @(negedge clkin);
    start = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [RES_W-1:0] exp);
    check(name, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clkin);
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic [SCYC_W-1:0] sc;
    logic [RES_W-1:0]  res;
    int                width;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int fall;
    int hit;

    vecs[0] = '{sc: 8'd5, res: 12'hA5C, width: 5};
    vecs[1] = '{sc: 8'd0, res: 12'h123, width: 3};
    vecs[2] = '{sc: 8'd1, res: 12'h456, width: 3};
    vecs[3] = '{sc: 8'd3, res: 12'h800, width: 3};
    vecs[4] = '{sc: 8'd9, res: 12'h001, width: 9};

    // Reset values, observed without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_st_conv", st_conv, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);

    // Pop while empty is ignored.
    rd_en = 1'b1;
    @(negedge clkin);
    rd_en = 1'b0;
    check("empty_pop_count", fifo_count, 0);
    check("empty_pop_empty", fifo_empty, 1);

    // Single shots: sample width, clamp, capture and FWFT head.
    for (int i = 0; i < 5; i++) begin
      res_q.push_back(vecs[i].res);
      pulse_start(vecs[i].sc);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_width", i), last_width, vecs[i].width);
      check($sformatf("vec%0d_count", i), fifo_count, 1);
      check($sformatf("vec%0d_empty", i), fifo_empty, 0);
      pop_check($sformatf("vec%0d_rd_data", i), vecs[i].res);
      check($sformatf("vec%0d_empty_after_pop", i), fifo_empty, 1);
      check($sformatf("vec%0d_rd_data_after_pop", i), rd_data, 0);
      check($sformatf("vec%0d_overflow", i), overflow, 0);
    end

    // Continuous with overflow: five results into a depth-4 FIFO.
    for (int i = 1; i <= 5; i++) res_q.push_back(RES_W'(i));
    sample_cycles = 8'd4;
    continuous = 1'b1;
    for (int i = 1; i <= 5; i++) wait_done_rise($sformatf("ovf_done%0d", i));
    continuous = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_count", fifo_count, 4);
    check("ovf_full", fifo_full, 1);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_pop%0d", i), RES_W'(i));
    check("ovf_empty", fifo_empty, 1);
    check("ovf_rd_data_zero", rd_data, 0);
    clr_flags = 1'b1;
    @(negedge clkin);
    clr_flags = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the capture cycle: accepted, no overflow.
    res_q.push_back(12'h011);
    res_q.push_back(12'h022);
    res_q.push_back(12'h033);
    res_q.push_back(12'h044);
    res_q.push_back(12'h7FF);
    continuous = 1'b1;
    for (int i = 1; i <= 5; i++) wait_done_rise($sformatf("fp_done%0d", i));
    continuous = 1'b0;
    repeat (3) @(posedge clkin);
    #1 rd_en = 1'b1;
    @(posedge clkin);
    #1 rd_en = 1'b0;
    @(negedge clkin);
    wait_idle("fp_idle");
    check("fp_overflow", overflow, 0);
    check("fp_count", fifo_count, 4);
    check("fp_full", fifo_full, 1);
    pop_check("fp_pop1", 12'h022);
    pop_check("fp_pop2", 12'h033);
    pop_check("fp_pop3", 12'h044);
    pop_check("fp_pop4", 12'h7FF);
    check("fp_empty", fifo_empty, 1);

    // Timeout: ADC never answers.
    adc_enable = 1'b0;
    pulse_start(8'd4);
    fall = -1;
    hit = -1;
    for (int n = 0; n < 300 && hit < 0; n++) begin
      @(negedge clkin);
      if (fall < 0 && !st_conv) fall = cyc;
      if (hit < 0 && timeout) hit = cyc;
    end
    check("to_latency", hit - fall, TIMEOUT_CYC);
    check("to_busy", busy, 0);
    check("to_no_write", fifo_count, 0);
    check("to_flag", timeout, 1);
    clr_flags = 1'b1;
    @(negedge clkin);
    clr_flags = 1'b0;
    check("to_cleared", timeout, 0);
    adc_enable = 1'b1;

    // Async reset mid-sample with two words queued.
    res_q.push_back(12'h0AA);
    pulse_start(8'd4);
    wait_idle("ar_shot1");
    res_q.push_back(12'h0BB);
    pulse_start(8'd4);
    wait_idle("ar_shot2");
    check("ar_count_before", fifo_count, 2);
    pulse_start(8'd20);
    repeat (6) @(negedge clkin);
    #2 rst = 1'b1;
    #1;
    check("ar_st_conv", st_conv, 0);
    check("ar_count", fifo_count, 0);
    check("ar_empty", fifo_empty, 1);
    check("ar_busy", busy, 0);
    check("ar_rd_data", rd_data, 0);
    check("ar_flags", {overflow, timeout}, 0);
    @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    res_q.push_back(12'h3C3);
    pulse_start(8'd6);
    wait_idle("ar_after");
    check("ar_after_width", last_width, 6);
    check("ar_after_count", fifo_count, 1);
    check("ar_after_rd_data", rd_data, 12'h3C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
